// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, Funct3 access
// encodings and lane widths.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned ByteW = 8;
    localparam int unsigned HalfW = 16;
    localparam int unsigned WordW = 32;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU. The request side produces byte enables, replicated store
// data and the reject flag; the response side extracts and extends the loaded lane.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]       req_addr_lo_i,
    input  logic [2:0]       req_funct3_i,
    input  logic             req_rd_i,
    input  logic             req_wr_i,
    input  logic [WordW-1:0] req_sdata_i,
    output logic [3:0]       req_be_o,
    output logic [WordW-1:0] req_wdata_o,
    output logic             req_misaligned_o,
    input  logic [1:0]       rsp_addr_lo_i,
    input  logic [2:0]       rsp_funct3_i,
    input  logic [WordW-1:0] rsp_rdata_i,
    output logic [WordW-1:0] rsp_data_o
);

    logic [WordW-1:0] lane;

    always_comb begin
        req_be_o         = 4'b0000;
        req_wdata_o      = req_sdata_i;
        req_misaligned_o = 1'b0;
        case (req_funct3_i)
            F3_B, F3_BU: begin
                req_be_o    = 4'b0001 << req_addr_lo_i;
                req_wdata_o = {4{req_sdata_i[ByteW-1:0]}};
            end
            F3_H, F3_HU: begin
                req_be_o         = 4'b0011 << req_addr_lo_i;
                req_wdata_o      = {2{req_sdata_i[HalfW-1:0]}};
                req_misaligned_o = req_addr_lo_i[0];
            end
            F3_W: begin
                req_be_o         = 4'b1111;
                req_misaligned_o = |req_addr_lo_i;
            end
            default: req_misaligned_o = 1'b1;
        endcase
        // Unsigned variants only make sense for loads; a simultaneous read+write is illegal.
        if (req_wr_i && ((req_funct3_i == F3_BU) || (req_funct3_i == F3_HU))) begin
            req_misaligned_o = 1'b1;
        end
        if (req_rd_i && req_wr_i) begin
            req_misaligned_o = 1'b1;
        end
    end

    always_comb begin
        lane = rsp_rdata_i >> {rsp_addr_lo_i, 3'b000};
        case (rsp_funct3_i)
            F3_B:    rsp_data_o = {{(WordW-ByteW){lane[ByteW-1]}}, lane[ByteW-1:0]};
            F3_BU:   rsp_data_o = {{(WordW-ByteW){1'b0}}, lane[ByteW-1:0]};
            F3_H:    rsp_data_o = {{(WordW-HalfW){lane[HalfW-1]}}, lane[HalfW-1:0]};
            F3_HU:   rsp_data_o = {{(WordW-HalfW){1'b0}}, lane[HalfW-1:0]};
            default: rsp_data_o = rsp_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns EX-stage loads/stores into req/ack bus transactions, extends load
// data, and reports rejected accesses and bus timeouts as one-cycle pulses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall,
    output logic                  ld_valid,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  misaligned,
    output logic                  bus_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_e            state_q;
    logic [CntW-1:0]       cnt_q;
    logic [1:0]            addr_lo_q;
    logic [2:0]            funct3_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [3:0]            mem_be_q;
    logic                  ld_valid_q;
    logic [DATA_WIDTH-1:0] ld_data_q;
    logic                  misaligned_q;
    logic                  bus_err_q;

    logic                  accept;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_bad;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign accept = ex_valid && (MemRead || MemWrite);

    lsu_align u_align (
        .req_addr_lo_i    (ALUResult[1:0]),
        .req_funct3_i     (Funct3),
        .req_rd_i         (MemRead),
        .req_wr_i         (MemWrite),
        .req_sdata_i      (StoreData),
        .req_be_o         (req_be),
        .req_wdata_o      (req_wdata),
        .req_misaligned_o (req_bad),
        .rsp_addr_lo_i    (addr_lo_q),
        .rsp_funct3_i     (funct3_q),
        .rsp_rdata_i      (mem_rdata),
        .rsp_data_o       (rsp_data)
    );

    // Combinational so EX holds the instruction in the very cycle it is accepted.
    assign stall = ((state_q == StIdle) && accept && !req_bad) || (state_q == StReq);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_lo_q    <= '0;
            funct3_q     <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            ld_valid_q   <= 1'b0;
            ld_data_q    <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            ld_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (req_bad) begin
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= StReq;
                            cnt_q       <= '0;
                            addr_lo_q   <= ALUResult[1:0];
                            funct3_q    <= Funct3;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MemWrite;
                            mem_addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                            mem_wdata_q <= req_wdata;
                            mem_be_q    <= req_be;
                        end
                    end
                end
                StReq: begin
                    // An ack on the last permitted cycle still completes normally.
                    if (mem_ack) begin
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            ld_valid_q <= 1'b1;
                            ld_data_q  <= rsp_data;
                        end
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign ld_valid   = ld_valid_q;
    assign ld_data    = ld_data_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for loads, stores, rejects,
// timeout, ack-at-limit and asynchronous reset during a request.
module tb_load_store_unit;

    localparam int unsigned TO = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, StoreData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, ld_valid, misaligned, bus_err;
    logic [31:0] ld_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse/cycle counters sampled on the active edge (pre-update values).
    int ldv_cnt = 0, req_cyc = 0, berr_cnt = 0, mis_cnt = 0;

    // Snapshot of the bus and stall taken by the access task.
    logic        s_stall_acc, s_stall_ack, s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    int          base_req, base_ldv;
    logic        seen;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .ALUResult  (ALUResult),
        .StoreData  (StoreData),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    always @(posedge clk) begin
        if (ld_valid)   ldv_cnt++;
        if (mem_req)    req_cyc++;
        if (bus_err)    berr_cnt++;
        if (misaligned) mis_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept at the first negedge, hold off ack for 'waits' REQ cycles, then ack.
    // Returns at the negedge of the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input int waits, input logic [31:0] rdata);
        @(negedge clk);
        ex_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
        ALUResult = addr; StoreData = sd;
        #1 s_stall_acc = stall;
        @(negedge clk);
        ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        s_we = mem_we; s_be = mem_be; s_addr = mem_addr; s_wdata = mem_wdata;
        repeat (waits) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rdata;
        #1 s_stall_ack = stall;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    // Present a rejected access and check the pulse with no bus activity.
    task automatic reject(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr);
        base_req = req_cyc;
        @(negedge clk);
        ex_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr;
        #1 chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        chk({tag, "_pulse"}, {31'b0, misaligned}, 32'd1);
        chk({tag, "_noreq"}, {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'b0, misaligned}, 32'd0);
        chk({tag, "_noreq_cyc"}, req_cyc - base_req, 32'd0);
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b0; ALUResult = 32'h0; StoreData = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'b0, mem_req}, 32'd0);
        chk("rst_be",    {28'b0, mem_be}, 32'd0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_ldata", ld_data, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        reset = 1'b1;

        // LW 0x100, three wait cycles.
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        chk("lw_stall_acc", {31'b0, s_stall_acc}, 32'd1);
        chk("lw_stall_ack", {31'b0, s_stall_ack}, 32'd1);
        chk("lw_be",        {28'b0, s_be}, 32'hF);
        chk("lw_addr",      s_addr, 32'h100);
        chk("lw_we",        {31'b0, s_we}, 32'd0);
        chk("lw_ldv",       {31'b0, ld_valid}, 32'd1);
        chk("lw_data",      ld_data, 32'hDEADBEEF);
        chk("lw_stall_done", {31'b0, stall}, 32'd0);
        @(negedge clk);
        chk("lw_ldv_end",   {31'b0, ld_valid}, 32'd0);

        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80000000);
        chk("lb_be",   {28'b0, s_be}, 32'h8);
        chk("lb_data", ld_data, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80000000);
        chk("lbu_data", ld_data, 32'h00000080);
        access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'hBEEF0000);
        chk("lhu_be",   {28'b0, s_be}, 32'hC);
        chk("lhu_data", ld_data, 32'h0000BEEF);

        // Stores: lane replication and byte enables; no load pulse.
        access(1'b0, 1'b1, 3'b000, 32'h201, 32'h123456AB, 1, 32'h0);
        chk("sb_we",    {31'b0, s_we}, 32'd1);
        chk("sb_be",    {28'b0, s_be}, 32'h2);
        chk("sb_wdata", s_wdata, 32'hABABABAB);
        chk("sb_addr",  s_addr, 32'h200);
        chk("sb_noldv", {31'b0, ld_valid}, 32'd0);
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 0, 32'h0);
        chk("sh_be",    {28'b0, s_be}, 32'hC);
        chk("sh_wdata", s_wdata, 32'hBEEFBEEF);

        reject("mis_lw",  1'b1, 1'b0, 3'b010, 32'h102);
        reject("mis_sh",  1'b0, 1'b1, 3'b001, 32'h301);
        reject("ill_f3",  1'b1, 1'b0, 3'b011, 32'h100);
        reject("ill_sbu", 1'b0, 1'b1, 3'b100, 32'h100);
        reject("ill_rw",  1'b1, 1'b1, 3'b010, 32'h100);

        // Timeout: no ack at all.
        base_req = req_cyc;
        @(negedge clk);
        ex_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h400;
        @(negedge clk);
        ex_valid = 1'b0; MemRead = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 * TO && !seen; i++) begin
            @(negedge clk);
            seen = bus_err;
        end
        chk("to_berr",  {31'b0, seen}, 32'd1);
        chk("to_reqcyc", req_cyc - base_req, TO);
        chk("to_req_off", {31'b0, mem_req}, 32'd0);
        chk("to_stall",  {31'b0, stall}, 32'd0);
        @(negedge clk);
        chk("to_berr_end", {31'b0, bus_err}, 32'd0);

        // Ack on the final permitted cycle wins over the timeout.
        access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, TO - 1, 32'h5A5A0F0F);
        chk("last_ldv",  {31'b0, ld_valid}, 32'd1);
        chk("last_data", ld_data, 32'h5A5A0F0F);
        chk("last_berr_cnt", berr_cnt, 32'd1);

        // Asynchronous reset while requesting.
        @(negedge clk);
        ex_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h600;
        @(negedge clk);
        ex_valid = 1'b0; MemRead = 1'b0;
        chk("ar_req_on", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1 chk("ar_req_off", {31'b0, mem_req}, 32'd0);
        base_ldv = ldv_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_no_ldv", ldv_cnt - base_ldv, 32'd0);

        // Back-to-back LW then SW.
        access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0, 32'h11223344);
        chk("b2b_lw_addr", s_addr, 32'h500);
        chk("b2b_lw_data", ld_data, 32'h11223344);
        access(1'b0, 1'b1, 3'b010, 32'h504, 32'hCAFEF00D, 1, 32'hFFFFFFFF);
        chk("b2b_sw_addr",  s_addr, 32'h504);
        chk("b2b_sw_wdata", s_wdata, 32'hCAFEF00D);
        chk("b2b_sw_be",    {28'b0, s_be}, 32'hF);
        chk("b2b_sw_noldv", {31'b0, ld_valid}, 32'd0);
        chk("b2b_hold",     ld_data, 32'h11223344);
        @(negedge clk);
        chk("ldv_total", ldv_cnt, 32'd6);
        chk("mis_total", mis_cnt, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
